cone_bist_sequencer: RTL and testbench

- Built-in self-test sequencer for single-output combinational cones extracted from the sequential benchmarks (e.g. the s1423 partial-output cones).
- Drives pseudo-random vectors onto the cone inputs and waits a fixed settle time per vector.
- Captures the cone output, compacts it into a MISR signature and counts mismatches against a golden copy (fault-free cone or model).
- Sits between the fault-injection harness and the cone under test; one instance per cone.

---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_lfsr32.sv | 39 +++
 rtl/cone_bist_sequencer.sv | 152 +++++++++++++++
 tb/tb_cone_bist_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the cone BIST sequencer
package bist_pkg;

    localparam int          MISR_W    = 16;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_APPLY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } bist_state_t;

    // One Galois step, shifting right; the feedback bit is the bit shifted out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// rtl/bist_lfsr32.sv - 32-bit Galois pattern generator with zero-seed substitution
module bist_lfsr32
    import bist_pkg::*;
#(
    parameter int N_OUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      seed,
    input  logic             step,
    output logic [N_OUT-1:0] load_vec,
    output logic [N_OUT-1:0] step_vec
);

    logic [31:0] lfsr;
    logic [31:0] seed_eff;
    logic [31:0] lfsr_nxt;

    // An all-zero state would lock the generator, so a zero seed becomes 1.
    assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;
    assign lfsr_nxt = lfsr_step(lfsr);

    // The caller registers these as the next cone vector alongside the load/step.
    assign load_vec = seed_eff[N_OUT-1:0];
    assign step_vec = lfsr_nxt[N_OUT-1:0];

    // Generator state: load has precedence over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 32'h1;
        end else if (load) begin
            lfsr <= seed_eff;
        end else if (step) begin
            lfsr <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/cone_bist_sequencer.sv
// rtl/cone_bist_sequencer.sv - applies LFSR vectors to a cone, compacts and compares responses
module cone_bist_sequencer
    import bist_pkg::*;
#(
    parameter int N_IN   = 29,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    input  logic [CNT_W-1:0]  num_patterns,
    output logic [N_IN-1:0]   cone_in,
    input  logic              cone_out,
    input  logic              golden,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic              fail
);

    localparam int             SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);

    bist_state_t        state;
    logic [CNT_W-1:0]   np_q;
    logic [CNT_W-1:0]   idx;
    logic [SW-1:0]      settle_cnt;
    logic [N_IN-1:0]    load_vec;
    logic [N_IN-1:0]    step_vec;
    logic               lfsr_load;
    logic               lfsr_adv;
    logic               miscompare;
    logic [MISR_W-1:0]  misr_nxt;

    // An abort suppresses the generator update so the run state freezes as-is.
    assign lfsr_load  = (state == S_LOAD) && !abort;
    assign lfsr_adv   = (state == S_CAPTURE) && !abort;
    assign miscompare = cone_out ^ golden;
    assign misr_nxt   = {signature[MISR_W-2:0], 1'b0}
                      ^ (signature[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                      ^ {{(MISR_W-1){1'b0}}, cone_out};

    bist_lfsr32 #(
        .N_OUT (N_IN)
    ) u_lfsr (
        .clk      (CK),
        .rst      (RST),
        .load     (lfsr_load),
        .seed     (seed),
        .step     (lfsr_adv),
        .load_vec (load_vec),
        .step_vec (step_vec)
    );

    // Run sequencing, response compaction and result registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            state          <= S_IDLE;
            np_q           <= '0;
            idx            <= '0;
            settle_cnt     <= '0;
            cone_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            signature      <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '1;
            fail           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        np_q           <= num_patterns;
                        signature      <= '0;
                        mismatch_cnt   <= '0;
                        fail           <= 1'b0;
                        idx            <= '0;
                        first_fail_idx <= '1;
                        busy           <= 1'b1;
                        state          <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cone_in <= load_vec;
                        if (np_q == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        settle_cnt <= '0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        signature <= misr_nxt;
                        if (miscompare) begin
                            if (mismatch_cnt != '1) begin
                                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                            end
                            if (!fail) begin
                                first_fail_idx <= idx;
                            end
                            fail <= 1'b1;
                        end
                        cone_in <= step_vec;
                        if (idx == np_q - CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + CNT_W'(1);
                            state <= S_APPLY;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cone_bist_sequencer.sv
// tb/tb_cone_bist_sequencer.sv - self-checking bench for cone_bist_sequencer
module tb_cone_bist_sequencer;

    localparam int S1 = 3;  // SETTLE + 1 cycles per vector

    logic        CK;
    logic        RST;
    logic        start;
    logic        abort;
    logic [31:0] seed;
    logic [15:0] num_patterns;
    logic [28:0] cone_in;
    logic        cone_out;
    logic        golden;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] mismatch_cnt;
    logic [15:0] first_fail_idx;
    logic        fail;

    int checks = 0;
    int errors = 0;
    int gmode  = 0;  // 0: golden matches, 1: golden always wrong, 2: wrong only on vector 2
    logic g_flip;

    cone_bist_sequencer #(.N_IN(29), .SETTLE(2), .CNT_W(16)) dut (
        .CK             (CK),
        .RST            (RST),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .num_patterns   (num_patterns),
        .cone_in        (cone_in),
        .cone_out       (cone_out),
        .golden         (golden),
        .busy           (busy),
        .done           (done),
        .signature      (signature),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .fail           (fail)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Stand-in for the s1423_n85 cone.
    function automatic logic cone_fn(input logic [28:0] v);
        return (^(v & 29'h0B5A3C71)) ^ (v[3] & v[17]);
    endfunction

    // Run model: per-vector tables, results indexed by number of completed captures.
    logic [28:0] r_vec [0:16];
    logic [15:0] r_sig [0:16];
    logic [15:0] r_mm  [0:16];
    logic [15:0] r_ff  [0:16];
    logic        r_fl  [0:16];
    bit          m_valid = 0;
    bit          m_run   = 0;
    int          m_t, m_T, m_N;
    logic [28:0] m_prev_cone;
    logic [28:0] h_cone;
    logic [15:0] h_sig, h_mm, h_ff;
    logic        h_fail;

    assign cone_out = cone_fn(cone_in);
    always_comb begin
        g_flip = 1'b0;
        if (gmode == 1) g_flip = 1'b1;
        else if (gmode == 2) g_flip = (cone_in == r_vec[2]);
    end
    assign golden = cone_out ^ g_flip;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic build_run(input logic [31:0] sd, input int n, input int mode);
        logic [31:0] l;
        logic [15:0] sg, mm, ff;
        logic        fl, o, g;
        l = (sd == 32'h0) ? 32'h1 : sd;
        for (int k = 0; k <= n; k++) begin
            r_vec[k] = l[28:0];
            l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
        end
        sg = 16'h0; mm = 16'h0; ff = 16'hFFFF; fl = 1'b0;
        r_sig[0] = sg; r_mm[0] = mm; r_ff[0] = ff; r_fl[0] = fl;
        for (int k = 0; k < n; k++) begin
            o = cone_fn(r_vec[k]);
            g = o ^ ((mode == 1) || (mode == 2 && k == 2));
            sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0) ^ {15'b0, o};
            if (o != g) begin
                if (mm != 16'hFFFF) mm = mm + 16'd1;
                if (!fl) ff = 16'(k);
                fl = 1'b1;
            end
            r_sig[k+1] = sg; r_mm[k+1] = mm; r_ff[k+1] = ff; r_fl[k+1] = fl;
        end
    endtask

    task automatic get_exp(output logic [28:0] e_cone, output logic e_busy, output logic e_done,
                           output logic [15:0] e_sig, output logic [15:0] e_mm,
                           output logic [15:0] e_ff, output logic e_fail);
        int c;
        if (!m_run) begin
            e_cone = h_cone; e_busy = 1'b0; e_done = 1'b0;
            e_sig = h_sig; e_mm = h_mm; e_ff = h_ff; e_fail = h_fail;
        end else begin
            c = (m_t < 2) ? 0 : (m_t - 2) / S1;
            if (c > m_N) c = m_N;
            e_cone = (m_t < 2) ? m_prev_cone : r_vec[c];
            e_busy = (m_t < m_T);
            e_done = (m_t == m_T);
            e_sig = r_sig[c]; e_mm = r_mm[c]; e_ff = r_ff[c]; e_fail = r_fl[c];
        end
    endtask

    // Model advance on each active edge, from the same inputs the DUT samples.
    always @(posedge CK) begin
        logic [28:0] ec;
        logic        eb, ed;
        if (RST) begin
            m_valid = 1; m_run = 0;
            h_cone = '0; h_sig = '0; h_mm = '0; h_ff = 16'hFFFF; h_fail = 1'b0;
        end else if (m_valid) begin
            if (m_run) begin
                if (m_t == m_T || (abort && m_t < m_T)) begin
                    get_exp(ec, eb, ed, h_sig, h_mm, h_ff, h_fail);
                    h_cone = ec;
                    m_run  = 0;
                end else begin
                    m_t++;
                end
            end else if (start) begin
                m_prev_cone = h_cone;
                m_N = int'(num_patterns);
                build_run(seed, m_N, gmode);
                m_t = 1;
                m_T = 2 + m_N * S1;
                m_run = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CK) begin
        logic [28:0] ec;
        logic        eb, ed, ef;
        logic [15:0] es, em, eff;
        if (m_valid) begin
            get_exp(ec, eb, ed, es, em, eff, ef);
            chk("cone_in", cone_in, ec);
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("signature", signature, es);
            chk("mismatch_cnt", mismatch_cnt, em);
            chk("first_fail_idx", first_fail_idx, eff);
            chk("fail", fail, ef);
        end
    end

    int cycles;

    // Assert start for one cycle; cycles counts cycles after the accepting edge.
    task automatic do_start(input logic [31:0] sd, input logic [15:0] n);
        @(negedge CK);
        seed = sd; num_patterns = n; start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        num_patterns = 16'h0003;  // must not affect the run in progress
        cycles = 1;
    endtask

    task automatic wait_done(input int exp_cycle, input string nm);
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge CK);
            cycles++;
        end
        chk(nm, cycles, exp_cycle);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_patterns = '0;
        repeat (3) @(negedge CK);
        RST = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            if (i == 0 || i == 19) begin
                chk("idle_busy", busy, 0);
                chk("idle_ffi", first_fail_idx, 32'hFFFF);
                chk("idle_cone_in", cone_in, 0);
                chk("idle_done", done, 0);
            end
        end

        // Clean run, seed 1, 4 vectors
        gmode = 0;
        do_start(32'h1, 16'd4);
        chk("model_vec1", r_vec[1], 32'h00200003);
        chk("model_vec2", r_vec[2], 32'h00300002);
        wait_done(14, "latency_n4");
        chk("cone_in_after_4", cone_in, 32'h102C0003);
        chk("clean_mm", mismatch_cnt, 0);
        chk("clean_fail", fail, 0);
        chk("clean_ffi", first_fail_idx, 32'hFFFF);

        // All vectors mismatch
        gmode = 1;
        do_start(32'h1, 16'd4);
        wait_done(14, "latency_allbad");
        chk("allbad_mm", mismatch_cnt, 4);
        chk("allbad_ffi", first_fail_idx, 0);
        chk("allbad_fail", fail, 1);

        // Only vector 2 mismatches
        gmode = 2;
        do_start(32'h1, 16'd4);
        wait_done(14, "latency_v2bad");
        chk("v2bad_mm", mismatch_cnt, 1);
        chk("v2bad_ffi", first_fail_idx, 2);

        // Zero patterns, zero seed
        gmode = 0;
        do_start(32'h0, 16'd0);
        chk("n0_busy_load", busy, 1);
        chk("n0_cleared_mm", mismatch_cnt, 0);
        wait_done(2, "latency_n0");
        chk("n0_sig", signature, 0);
        chk("n0_cone_in", cone_in, 1);

        // Abort in second APPLY cycle of vector 1
        gmode = 1;
        do_start(32'h12345678, 16'd8);
        repeat (5) @(negedge CK);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mm", mismatch_cnt, 1);
        chk("abort_ffi", first_fail_idx, 0);
        chk("abort_fail", fail, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            if (done !== 1'b0) chk("abort_no_done", done, 0);
        end
        gmode = 0;
        do_start(32'h0000ACE1, 16'd3);
        chk("restart_mm", mismatch_cnt, 0);
        chk("restart_fail", fail, 0);
        chk("restart_ffi", first_fail_idx, 32'hFFFF);
        wait_done(11, "latency_n3");

        // Reset during CAPTURE of vector 3
        gmode = 1;
        do_start(32'h7, 16'd6);
        repeat (12) @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_cone_in", cone_in, 0);
        chk("rst_mm", mismatch_cnt, 0);
        chk("rst_ffi", first_fail_idx, 32'hFFFF);
        chk("rst_sig", signature, 0);
        gmode = 2;
        do_start(32'h5, 16'd4);
        wait_done(14, "latency_after_rst");
        chk("after_rst_ffi", first_fail_idx, 2);
        chk("after_rst_mm", mismatch_cnt, 1);

        repeat (3) @(negedge CK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
